stoch_sum_decimator: RTL and testbench

Windowed decimating accumulator that sits directly downstream of the 16-input adder tree. It consumes one per-cycle popcount of a bank of stochastic bitstreams and sums 2^WINDOW_LOG2 valid samples into a single binary result. The result is presented on a valid/ready output port, so downstream binary logic can read a decoded estimate of the summed stochastic value once per window.

---
 rtl/stoch_sum_decimator.sv | 60 ++++++
 tb/tb_stoch_sum_decimator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stoch_sum_decimator.sv
// stoch_sum_decimator: sums 2^WINDOW_LOG2 valid popcount samples and presents each window total on a valid/ready port.
// Optional sticky overrun output (dropped window results) is enabled by defining BITSAD_DECIM_OVERRUN_EN.
module stoch_sum_decimator #(
    parameter int IN_WIDTH = 5,
    parameter int WINDOW_LOG2 = 8,
    localparam int OUT_WIDTH = IN_WIDTH + WINDOW_LOG2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    input  logic [IN_WIDTH-1:0]    in_sum,
    input  logic                   clear,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [OUT_WIDTH-1:0]   out_sum,
    output logic [WINDOW_LOG2-1:0] sample_cnt
`ifdef BITSAD_DECIM_OVERRUN_EN
    ,
    output logic                   overrun
`endif
);
    logic [OUT_WIDTH-1:0]   acc;
    logic [OUT_WIDTH-1:0]   sum_next;
    logic [WINDOW_LOG2-1:0] cnt;
    logic                   complete;
    logic                   slot_free;
    assign sum_next   = acc + OUT_WIDTH'(in_sum);
    assign complete   = in_valid && !clear && (cnt == '1);
    assign slot_free  = !out_valid || out_ready;
    assign sample_cnt = cnt;
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (in_valid) begin
                acc <= (cnt == '1) ? '0 : sum_next;
                cnt <= cnt + 1'b1;
            end
            // a completing window may refill the slot on the same edge it is consumed
            if (complete && slot_free) begin
                out_sum   <= sum_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
`ifdef BITSAD_DECIM_OVERRUN_EN
    always_ff @(posedge CLK) begin
        if (RST) overrun <= 1'b0;
        else if (complete && !slot_free) overrun <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_stoch_sum_decimator.sv
// tb_stoch_sum_decimator: directed bench with a result scoreboard for stoch_sum_decimator (WINDOW_LOG2=2 and 8).
module tb_stoch_sum_decimator;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [4:0]  in_sum = '0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [6:0]  out_sum;
    logic [1:0]  sample_cnt;
    logic        v8 = 1'b0;
    logic [4:0]  s8 = '0;
    logic        out_valid8;
    logic [12:0] out_sum8;
    logic [7:0]  cnt8;
`ifdef BITSAD_DECIM_OVERRUN_EN
    logic        overrun;
    logic        overrun8;
`endif
    int          total = 0;
    int          passed = 0;
    logic [31:0] sb[$];

    always #5 CLK = ~CLK;

    stoch_sum_decimator #(.IN_WIDTH(5), .WINDOW_LOG2(2)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_sum(in_sum), .clear(clear),
        .out_ready(out_ready), .out_valid(out_valid), .out_sum(out_sum), .sample_cnt(sample_cnt)
`ifdef BITSAD_DECIM_OVERRUN_EN
        , .overrun(overrun)
`endif
    );

    stoch_sum_decimator #(.IN_WIDTH(5), .WINDOW_LOG2(8)) dut8 (
        .CLK(CLK), .RST(RST), .in_valid(v8), .in_sum(s8), .clear(1'b0),
        .out_ready(1'b1), .out_valid(out_valid8), .out_sum(out_sum8), .sample_cnt(cnt8)
`ifdef BITSAD_DECIM_OVERRUN_EN
        , .overrun(overrun8)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input logic v, input logic [4:0] s);
        in_valid = v;
        in_sum = s;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        sb.delete();
        step(1'b0, 5'd0);
        RST = 1'b0;
    endtask

    // scoreboard: inputs settle 1 time unit after posedge, so a transfer on the next edge is visible here
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else check("xfer_sum", 32'(out_sum), sb.pop_front());
        end
    end

    initial begin
        logic [4:0] basic[4] = '{5'd3, 5'd16, 5'd0, 5'd5};
        step(1'b0, 5'd0);
        do_reset();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(out_sum), 0);
        check("rst_cnt", 32'(sample_cnt), 0);
`ifdef BITSAD_DECIM_OVERRUN_EN
        check("rst_overrun", 32'(overrun), 0);
`endif
        out_ready = 1'b1;
        sb.push_back(24);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, basic[i]);
            check("basic_cnt", 32'(sample_cnt), 32'((i + 1) % 4));
        end
        check("basic_valid", 32'(out_valid), 1);
        check("basic_sum", 32'(out_sum), 24);
        step(1'b0, 5'd0);
        check("basic_valid_drop", 32'(out_valid), 0);
        sb.push_back(4);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd1);
            if (i < 3) begin
                step(1'b0, 5'd9);
                step(1'b0, 5'd9);
                check("gap_cnt_hold", 32'(sample_cnt), 32'(i + 1));
                check("gap_no_valid", 32'(out_valid), 0);
            end
        end
        check("gap_valid", 32'(out_valid), 1);
        check("gap_sum", 32'(out_sum), 4);
        step(1'b0, 5'd0);
        out_ready = 1'b0;
        sb.push_back(64);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 5'd16);
            if (i == 3) begin
                check("bp_first_valid", 32'(out_valid), 1);
                check("bp_first_sum", 32'(out_sum), 64);
`ifdef BITSAD_DECIM_OVERRUN_EN
                check("bp_overrun_early", 32'(overrun), 0);
`endif
            end
        end
        step(1'b0, 5'd0);
        check("bp_hold_valid", 32'(out_valid), 1);
        check("bp_hold_sum", 32'(out_sum), 64);
`ifdef BITSAD_DECIM_OVERRUN_EN
        check("bp_overrun", 32'(overrun), 1);
`endif
        out_ready = 1'b1;
        step(1'b0, 5'd0);
        check("bp_valid_fall", 32'(out_valid), 0);
`ifdef BITSAD_DECIM_OVERRUN_EN
        check("bp_overrun_sticky", 32'(overrun), 1);
`endif
        do_reset();
        out_ready = 1'b0;
        sb.push_back(10);
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i));
        check("sim_hold_sum", 32'(out_sum), 10);
        sb.push_back(8);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) out_ready = 1'b1;
            step(1'b1, 5'd2);
        end
        check("sim_valid", 32'(out_valid), 1);
        check("sim_sum", 32'(out_sum), 8);
`ifdef BITSAD_DECIM_OVERRUN_EN
        check("sim_overrun", 32'(overrun), 0);
`endif
        step(1'b0, 5'd0);
        check("sim_valid_fall", 32'(out_valid), 0);
        sb.push_back(4);
        step(1'b1, 5'd7);
        step(1'b1, 5'd7);
        clear = 1'b1;
        step(1'b1, 5'd9);
        check("clr_cnt", 32'(sample_cnt), 0);
        check("clr_no_valid", 32'(out_valid), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 5'd1);
        check("clr_sum", 32'(out_sum), 4);
        step(1'b0, 5'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 5'd1);
        clear = 1'b1;
        step(1'b1, 5'd1);
        check("clr_last_no_valid", 32'(out_valid), 0);
        check("clr_last_cnt", 32'(sample_cnt), 0);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 5'd1);
        check("pre_rst_valid", 32'(out_valid), 1);
        check("pre_rst_sum", 32'(out_sum), 4);
        step(1'b1, 5'd1);
        check("pre_rst_cnt", 32'(sample_cnt), 1);
        do_reset();
        check("rst2_valid", 32'(out_valid), 0);
        check("rst2_sum", 32'(out_sum), 0);
        check("rst2_cnt", 32'(sample_cnt), 0);
`ifdef BITSAD_DECIM_OVERRUN_EN
        check("rst2_overrun", 32'(overrun), 0);
`endif
        v8 = 1'b1;
        s8 = 5'd31;
        repeat (255) begin
            @(posedge CLK);
            #1;
        end
        check("fs_cnt", 32'(cnt8), 255);
        check("fs_no_valid", 32'(out_valid8), 0);
        @(posedge CLK);
        #1;
        v8 = 1'b0;
        check("fs_valid", 32'(out_valid8), 1);
        check("fs_sum", 32'(out_sum8), 7936);
        check("fs_cnt_wrap", 32'(cnt8), 0);
        check("sb_drain", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
